// File: rtl/iceb_out_bcd_if.sv
// rtl/iceb_out_bcd_if.sv - OUT register capture/display bus between CPU side and iceb_out_bcd
interface iceb_out_bcd_if;
    logic       out_strobe_i;
    logic [7:0] out_value_i;
    logic       decimal_mode_i;
    logic [7:0] display_o;
    logic [1:0] hundreds_o;
    logic       busy_o;
    logic       valid_o;

    modport master (
        output out_strobe_i, out_value_i, decimal_mode_i,
        input  display_o, hundreds_o, busy_o, valid_o
    );

    modport slave (
        input  out_strobe_i, out_value_i, decimal_mode_i,
        output display_o, hundreds_o, busy_o, valid_o
    );
endinterface

// File: rtl/iceb_out_bcd.sv
// rtl/iceb_out_bcd.sv - OUT register capture with hex or double-dabble decimal display formatting
module iceb_out_bcd #(
    parameter int MODE_SYNC_STAGES = 2,
    parameter bit COALESCE         = 1'b1
) (
    input logic           clk,
    input logic           reset_n,
    iceb_out_bcd_if.slave bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] LOAD  = 2'd2;

    // Reset asserts asynchronously but releases only on a clock edge.
    logic [1:0] rstSync;
    logic       rstn;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rstSync <= 2'b00;
        else          rstSync <= {rstSync[0], 1'b1};
    end
    assign rstn = rstSync[1];

    logic modeSynced;

    generate
        if (MODE_SYNC_STAGES == 0) begin : g_noSync
            assign modeSynced = bus.decimal_mode_i;
        end else begin : g_sync
            logic [MODE_SYNC_STAGES-1:0] syncFf;
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    syncFf <= '0;
                end else begin
                    syncFf[0] <= bus.decimal_mode_i;
                    for (int i = 1; i < MODE_SYNC_STAGES; i++) syncFf[i] <= syncFf[i-1];
                end
            end
            assign modeSynced = syncFf[MODE_SYNC_STAGES-1];
        end
    endgenerate

    logic [1:0]  state;
    logic [7:0]  shReg;
    logic        capMode;
    logic [11:0] bcd;
    logic [2:0]  count;
    logic        pendValid;
    logic [7:0]  pendValue;
    logic        pendMode;
    logic [7:0]  display;
    logic [1:0]  hundreds;
    logic        valid;

    // Shift-add-3 correction applied before every shift.
    logic [11:0] bcdAdj;
    always_comb begin
        bcdAdj = bcd;
        for (int n = 0; n < 3; n++) begin
            if (bcd[n*4 +: 4] >= 4'd5) bcdAdj[n*4 +: 4] = bcd[n*4 +: 4] + 4'd3;
        end
    end

    // A fresh strobe in LOAD beats an older pending value.
    logic       takeStrobe;
    logic       startNow;
    logic [7:0] startValue;
    logic       startMode;
    always_comb begin
        takeStrobe = bus.out_strobe_i && ((state == IDLE) || (state == LOAD && COALESCE));
        startNow   = takeStrobe || (state == LOAD && pendValid);
        startValue = takeStrobe ? bus.out_value_i : pendValue;
        startMode  = takeStrobe ? modeSynced : pendMode;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            shReg     <= 8'h00;
            capMode   <= 1'b0;
            bcd       <= 12'h000;
            count     <= 3'd0;
            pendValid <= 1'b0;
            pendValue <= 8'h00;
            pendMode  <= 1'b0;
            display   <= 8'h00;
            hundreds  <= 2'd0;
            valid     <= 1'b0;
        end else begin
            if (state == SHIFT) begin
                bcd   <= {bcdAdj[10:0], shReg[7]};
                shReg <= {shReg[6:0], 1'b0};
                count <= count + 3'd1;
                if (count == 3'd7) state <= LOAD;
                if (bus.out_strobe_i && COALESCE) begin
                    pendValid <= 1'b1;
                    pendValue <= bus.out_value_i;
                    pendMode  <= modeSynced;
                end
            end

            if (state == LOAD) begin
                display   <= capMode ? bcd[7:0] : shReg;
                hundreds  <= capMode ? bcd[9:8] : 2'd0;
                valid     <= 1'b1;
                pendValid <= 1'b0;
                state     <= IDLE;
            end

            if (startNow) begin
                shReg   <= startValue;
                capMode <= startMode;
                bcd     <= 12'h000;
                count   <= 3'd0;
                state   <= startMode ? SHIFT : LOAD;
            end
        end
    end

    assign bus.display_o  = display;
    assign bus.hundreds_o = hundreds;
    assign bus.busy_o     = (state == SHIFT) || (state == LOAD && capMode);
    assign bus.valid_o    = valid;
endmodule
